// File: rtl/square_wave_gen.sv
// Programmable period/duty square-wave generator.
// Settings are double-buffered and switch only on period boundaries.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   enable             1 = run, 0 = stop at end of current period
//   cfg_valid/ready    handshake for period_in/high_in
//   period_in          requested period in clk cycles
//   high_in            requested high time (0 = 50 % duty)
//   cfg_err            1-cycle pulse: request dropped (period too short)
//   wave_out           registered square wave
//   cycle_start        1-cycle pulse on first (high) cycle of a period
//   running            waveform being generated (RUN or draining STOP)
//   active_period      period in use (0 = none loaded)

module square_wave_gen #(
  parameter int COUNTER_WIDTH = 18,
  parameter int MIN_PERIOD    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [COUNTER_WIDTH-1:0] period_in,
  input  logic [COUNTER_WIDTH-1:0] high_in,
  output logic                     cfg_err,
  output logic                     wave_out,
  output logic                     cycle_start,
  output logic                     running,
  output logic [COUNTER_WIDTH-1:0] active_period
);

  localparam int CW = COUNTER_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STOP
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0] cnt;
  logic [CW-1:0] active_high;
  logic [CW-1:0] shd_period;
  logic [CW-1:0] shd_high;
  logic [CW-1:0] high_req;
  logic          pending;
  logic          accept;
  logic          too_short;
  logic          wrap;
  logic          load_active;

  assign cfg_ready = !pending;
  // STOP is still finishing a period, so it counts as running.
  assign running   = (state != IDLE);

  always_comb begin
    accept    = cfg_valid & cfg_ready;
    too_short = (period_in < CW'(MIN_PERIOD));
    // High time is clamped so the wave always has a low phase.
    high_req  = high_in;
    if (high_in == '0)
      high_req = period_in >> 1;
    else if (high_in >= period_in)
      high_req = period_in - CW'(1);
    wrap = (state != IDLE) &&
           (cnt == active_period - CW'(1));
    // pending is only ever set while cfg_ready was high,
    // so a same-edge accept is never consumed here.
    load_active = pending &&
                  ((state == IDLE) || wrap);
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (enable &&
            ((active_period != '0) || pending))
          state_nxt = RUN;
      end
      RUN: begin
        if (!enable)
          state_nxt = wrap ? IDLE : STOP;
      end
      STOP: begin
        if (enable)
          state_nxt = RUN;
        else if (wrap)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      active_period <= '0;
      active_high   <= '0;
      shd_period    <= '0;
      shd_high      <= '0;
      pending       <= 1'b0;
      cfg_err       <= 1'b0;
      wave_out      <= 1'b0;
      cycle_start   <= 1'b0;
    end else begin
      state   <= state_nxt;
      cfg_err <= accept & too_short;

      if (load_active) begin
        active_period <= shd_period;
        active_high   <= shd_high;
        pending       <= 1'b0;
      end
      if (accept && !too_short) begin
        shd_period <= period_in;
        shd_high   <= high_req;
        pending    <= 1'b1;
      end

      // Outputs trail cnt by one register stage.
      if (state == IDLE) begin
        cnt         <= '0;
        wave_out    <= 1'b0;
        cycle_start <= 1'b0;
      end else begin
        cnt         <= wrap ? '0 : cnt + CW'(1);
        wave_out    <= (cnt < active_high);
        cycle_start <= (cnt == '0);
      end
    end
  end

endmodule

// File: tb/tb_square_wave_gen.sv
// Directed bench for square_wave_gen with an
// expected-waveform scoreboard.
module tb_square_wave_gen;

  localparam int CW = 18;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [CW-1:0] period_in;
  logic [CW-1:0] high_in;
  logic          cfg_err;
  logic          wave_out;
  logic          cycle_start;
  logic          running;
  logic [CW-1:0] active_period;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic w;
    logic cs;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  square_wave_gen #(
    .COUNTER_WIDTH(CW),
    .MIN_PERIOD(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .period_in(period_in),
    .high_in(high_in),
    .cfg_err(cfg_err),
    .wave_out(wave_out),
    .cycle_start(cycle_start),
    .running(running),
    .active_period(active_period)
  );

  task automatic chk(string tag,
                     logic [31:0] obs,
                     logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push_per(int p, int h, int n);
    exp_t e;
    for (int k = 0; k < n; k++)
      for (int c = 0; c < p; c++) begin
        e.w  = (c < h);
        e.cs = (c == 0);
        sb.push_back(e);
      end
  endtask

  task automatic push_idle(int n);
    exp_t e;
    e.w  = 1'b0;
    e.cs = 1'b0;
    for (int k = 0; k < n; k++)
      sb.push_back(e);
  endtask

  task automatic step_check(string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s_sb_empty observed=0 expected=1",
             tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_wave"}, 32'(wave_out), 32'(e.w));
      chk({tag, "_cs"}, 32'(cycle_start), 32'(e.cs));
    end
    tick();
  endtask

  task automatic drain(string tag, int n);
    for (int k = 0; k < n; k++)
      step_check(tag);
  endtask

  task automatic set_cfg(int p, int h);
    cfg_valid = 1'b1;
    period_in = CW'(p);
    high_in   = CW'(h);
  endtask

  // Enable from IDLE: wave rises two clocks later.
  task automatic start_run(string tag);
    enable = 1'b1;
    tick();
    chk({tag, "_lat_wave0"}, 32'(wave_out), 0);
    chk({tag, "_lat_run"}, 32'(running), 1);
    tick();
  endtask

  initial begin
    rst       = 1'b1;
    enable    = 1'b0;
    cfg_valid = 1'b0;
    period_in = '0;
    high_in   = '0;
    tick();
    tick();
    chk("rst_wave", 32'(wave_out), 0);
    chk("rst_cs", 32'(cycle_start), 0);
    chk("rst_err", 32'(cfg_err), 0);
    chk("rst_run", 32'(running), 0);
    chk("rst_ready", 32'(cfg_ready), 1);
    chk("rst_active", 32'(active_period), 0);
    rst = 1'b0;
    tick();

    // Load 10/default duty while disabled.
    set_cfg(10, 0);
    tick();
    cfg_valid = 1'b0;
    chk("t2_ready_low", 32'(cfg_ready), 0);
    tick();
    chk("t2_ready_high", 32'(cfg_ready), 1);
    chk("t2_active", 32'(active_period), 10);
    chk("t2_idle_run", 32'(running), 0);
    push_per(10, 5, 3);
    start_run("t2");
    drain("t2", 30);

    // Mid-period reload to 20/3.
    push_per(10, 5, 1);
    push_per(20, 3, 2);
    set_cfg(20, 3);
    step_check("t3");
    cfg_valid = 1'b0;
    chk("t3_ready_low", 32'(cfg_ready), 0);
    drain("t3", 7);
    chk("t3_ready_prewrap", 32'(cfg_ready), 0);
    chk("t3_active_old", 32'(active_period), 10);
    step_check("t3");
    chk("t3_ready_wrap", 32'(cfg_ready), 1);
    chk("t3_active_new", 32'(active_period), 20);
    drain("t3", 41);

    // Too-short period is rejected.
    push_per(20, 3, 1);
    set_cfg(2, 0);
    step_check("t4");
    cfg_valid = 1'b0;
    chk("t4_err_pulse", 32'(cfg_err), 1);
    chk("t4_ready", 32'(cfg_ready), 1);
    chk("t4_active", 32'(active_period), 20);
    step_check("t4");
    chk("t4_err_clear", 32'(cfg_err), 0);
    drain("t4", 18);

    // high == period clamps to 7/1, then 4/4.
    push_per(20, 3, 1);
    push_per(8, 7, 2);
    set_cfg(8, 8);
    step_check("t5a");
    cfg_valid = 1'b0;
    drain("t5a", 35);
    push_per(8, 7, 1);
    push_per(8, 4, 2);
    set_cfg(8, 0);
    step_check("t5b");
    cfg_valid = 1'b0;
    drain("t5b", 23);
    chk("t5_active", 32'(active_period), 8);

    // Back to 10, then stop mid-period.
    push_per(8, 4, 1);
    push_per(10, 5, 1);
    set_cfg(10, 0);
    step_check("t6l");
    cfg_valid = 1'b0;
    drain("t6l", 17);
    push_per(10, 5, 1);
    push_idle(3);
    drain("t6a", 2);
    enable = 1'b0;
    drain("t6a", 3);
    chk("t6_stop_run", 32'(running), 1);
    drain("t6a", 4);
    chk("t6_idle_run", 32'(running), 0);
    drain("t6a", 4);
    chk("t6_idle_run2", 32'(running), 0);

    // Restart, drop enable, re-assert in STOP.
    push_per(10, 5, 3);
    start_run("t6b");
    drain("t6b", 2);
    enable = 1'b0;
    drain("t6b", 4);
    chk("t6_stop_run2", 32'(running), 1);
    enable = 1'b1;
    drain("t6b", 4);
    chk("t6_resume_run", 32'(running), 1);
    drain("t6b", 20);
    chk("sb_left", 32'(sb.size()), 0);

    // Reset held 3 clocks while running.
    rst = 1'b1;
    tick();
    chk("t1_wave", 32'(wave_out), 0);
    chk("t1_run", 32'(running), 0);
    chk("t1_ready", 32'(cfg_ready), 1);
    chk("t1_active", 32'(active_period), 0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("t1_post_wave", 32'(wave_out), 0);
    chk("t1_post_cs", 32'(cycle_start), 0);
    chk("t1_post_active", 32'(active_period), 0);
    tick();
    chk("t1_noload_idle", 32'(running), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
